mux_stream_rr: RTL and testbench
================================

# mux_stream_rr

Parametrised N-channel stream multiplexer with a registered output. Each channel presents data with a valid/ready handshake. The block forwards one word per cycle to a single downstream port. Channel selection is either manual, via the select input, or round-robin fair arbitration. It sits between multiple producer channels and one consumer, and supersedes the fixed 4:1 combinational mux used in earlier labs.

## Interface
- `WIDTH`, 1, data bits per channel.
- `CHANNELS`, 4, number of input channels (≥2).
- `SEL_W` is a derived localparam equal to `$clog2(CHANNELS)`; it is not overridable.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `W`  in  CHANNELS*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- `W_valid`  in  CHANNELS  per-channel valid.
- `W_ready`  out  CHANNELS  per-channel ready; combinational; at most one bit high.
- `mode`  in  1  selection mode: 0 = manual (use `S`), 1 = round-robin.
- `S`  in  SEL_W  manual channel select.
- `y`  out  WIDTH  registered output data.
- `y_valid`  out  1  output valid.
- `y_ready`  in  1  downstream ready.
- `y_sel`  out  SEL_W  index of the channel that produced the current `y`.

## Operation
- Single output register holds `y`, `y_sel` and `y_valid`.
- `load_en = !y_valid || y_ready`. The register may accept a new word when it is empty or is being drained in the same cycle.
- Grant, computed combinationally:
  - Manual (`mode`=0): candidate = `S`. Grant only if `S` < CHANNELS and `W_valid[S]`=1. An out-of-range `S` grants nothing.
  - Round-robin (`mode`=1): search `W_valid` starting at pointer `ptr` upward with wrap-around. The first set bit is granted. No grant if `W_valid`=0.
- `W_ready[i] = load_en && grant_valid && grant==i`. A transfer on channel i occurs when `W_valid[i] && W_ready[i]`.
- On a rising edge with `load_en`:
  - If a grant exists: `y` ← `W[grant]`, `y_sel` ← grant, `y_valid` ← 1.
  - If there is no grant: `y_valid` ← 0. `y` and `y_sel` hold their previous values.
- On a rising edge without `load_en` (`y_valid`=1, `y_ready`=0): all outputs hold and every `W_ready` bit is 0.
- `ptr` advances only on a round-robin transfer: `ptr` ← (grant+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
  - Manual-mode transfers do not modify `ptr`.
  - `ptr` is retained across mode changes.
- A `mode` or `S` change is sampled combinationally and takes effect on the current cycle's grant. A word already in `y` is unaffected.
- A producer may drop `W_valid` without a transfer. The block does not require valid to be sticky.

## Timing
- Reset values (asserted asynchronously, released synchronously to `clk`): `y`=0, `y_valid`=0, `y_sel`=0, `ptr`=0.
  - While `rst_n`=0: `W_ready`=0.
- Latency: data accepted on edge k appears on `y` with `y_valid`=1 immediately after edge k, i.e. one cycle.
- Throughput: one word per cycle while `y_ready`=1 and some granted channel is valid.
- Backpressure: with `y_valid`=1 and `y_ready`=0, `y` and `y_sel` are stable and no channel sees ready.
- Simultaneous drain and load: when `y_ready`=1 and a new grant exists, the old word leaves and the new one loads on the same edge, with no bubble.
- Reset mid-operation: a held word is discarded, `ptr` returns to 0, and no transfer completes on the edge where reset is asserted.
- Fairness: in round-robin with all channels continuously valid and `y_ready`=1, grants cycle 0,1,…,CHANNELS-1,0.

## Test plan
- Reset with WIDTH=8, CHANNELS=4: hold `rst_n`=0 with all `W_valid`=1 → `y`=0, `y_valid`=0, `y_sel`=0, `W_ready`=0. Release → the first transfer occurs on the next edge.
- Manual mode, `S`=2, `W`={8'h44,8'h33,8'h22,8'h11}, `W_valid`=4'b0100, `y_ready`=1 → `W_ready`=4'b0100, and after 1 edge `y`=8'h33, `y_sel`=2. Then set `W_valid[2]`=0 → next edge gives `y_valid`=0.
- Round-robin, all valid, `y_ready`=1 for 6 cycles → `y_sel` sequence is 0,1,2,3,0,1, with `y` matching each channel's data. `W_valid`=4'b1010 from `ptr`=0 → grants 1,3,1.
- Backpressure: `y_valid`=1 with `y`=8'hA5, `y_ready`=0 for 3 cycles while inputs change → `y` stays 8'hA5, `W_ready`=0. Raise `y_ready` → the next word loads on the same edge.
- Mode switch and out-of-range select, with CHANNELS=3:
  - Manual `S`=3 with all valid → no `W_ready` and `y_valid` drops to 0.
  - Switch to round-robin after `ptr`=2 → the first grant is 2, then 0.
- Reset mid-stream: assert `rst_n`=0 asynchronously while `y_valid`=1 and `y_ready`=0 → outputs clear immediately without waiting for `clk`. After release, round-robin restarts at channel 0.

Source files
------------

// File: rtl/mux_stream_rr_if.sv
// Stream bundle between N producer channels and one consumer for mux_stream_rr.
// Channel i data occupies W[i*WIDTH +: WIDTH]; y_sel names the channel that produced y.
interface mux_stream_rr_if #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] W;
    logic [CHANNELS-1:0]       W_valid;
    logic [CHANNELS-1:0]       W_ready;
    logic [WIDTH-1:0]          y;
    logic                      y_valid;
    logic                      y_ready;
    logic [SEL_W-1:0]          y_sel;

    modport master (
        output W, W_valid, y_ready,
        input  W_ready, y, y_valid, y_sel
    );

    modport slave (
        input  W, W_valid, y_ready,
        output W_ready, y, y_valid, y_sel
    );
endinterface

// File: rtl/mux_stream_rr.sv
// N-channel stream multiplexer with a registered output stage.
// Grants by manual select or round-robin; one word per cycle with no drain/load bubble.
module mux_stream_rr #(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] S,
    mux_stream_rr_if.slave   bus
);
    logic             load_en;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;

    assign load_en = !bus.y_valid || bus.y_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        grant_valid = 1'b0;
        grant       = '0;
        grant_data  = '0;
        if (!mode) begin
            // An out-of-range S never matches a channel index, so it grants nothing.
            for (int i = 0; i < CHANNELS; i++) begin
                if (S == SEL_W'(i) && bus.W_valid[i]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(i);
                    grant_data  = bus.W[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            // Offset k walks upward from ptr with wrap; the first valid channel wins.
            for (int k = 0; k < CHANNELS; k++) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (!grant_valid && bus.W_valid[i] &&
                        ((int'(ptr) + k) % CHANNELS) == i) begin
                        grant_valid = 1'b1;
                        grant       = SEL_W'(i);
                        grant_data  = bus.W[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.W_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.W_ready[i] = rst_n && load_en && grant_valid && (grant == SEL_W'(i));
        end
        ptr_next = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (!rst_n) begin
            bus.y       <= '0;
            bus.y_valid <= 1'b0;
            bus.y_sel   <= '0;
            ptr         <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                bus.y       <= grant_data;
                bus.y_sel   <= grant;
                bus.y_valid <= 1'b1;
                // Only round-robin transfers move the pointer; manual traffic leaves it alone.
                if (mode) begin
                    ptr <= ptr_next;
                end
            end else begin
                bus.y_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_stream_rr.sv
// Scoreboard bench for mux_stream_rr: a 4-channel and a 3-channel instance, 8-bit data.
// Expected {y_sel, y} words are queued at stimulus time and popped by per-instance monitors.
module tb_mux_stream_rr;
    logic       clk;
    logic       rst_n;
    logic       mode4;
    logic [1:0] s4;
    logic       mode3;
    logic [1:0] s3;

    mux_stream_rr_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
    mux_stream_rr_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

    mux_stream_rr #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode4),
        .S     (s4),
        .bus   (bus4.slave)
    );

    mux_stream_rr #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode3),
        .S     (s3),
        .bus   (bus3.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] exp4_q[$];
    logic [9:0] exp3_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each negedge with y_valid && y_ready is one word leaving on the next edge.
    always @(negedge clk) begin
        if (rst_n && bus4.y_valid && bus4.y_ready) begin
            if (exp4_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut4 unexpected word: got %0h", {bus4.y_sel, bus4.y});
            end else begin
                check("dut4 word", {22'd0, bus4.y_sel, bus4.y}, {22'd0, exp4_q.pop_front()});
            end
        end
        if (rst_n && bus3.y_valid && bus3.y_ready) begin
            if (exp3_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut3 unexpected word: got %0h", {bus3.y_sel, bus3.y});
            end else begin
                check("dut3 word", {22'd0, bus3.y_sel, bus3.y}, {22'd0, exp3_q.pop_front()});
            end
        end
    end

    initial begin
        logic [3:0] rr_ready [0:2];
        rr_ready[0] = 4'b0010;
        rr_ready[1] = 4'b1000;
        rr_ready[2] = 4'b0010;

        rst_n        = 1'b0;
        mode4        = 1'b1;
        s4           = 2'd0;
        bus4.W       = 32'h44332211;
        bus4.W_valid = 4'hF;
        bus4.y_ready = 1'b1;
        mode3        = 1'b0;
        s3           = 2'd0;
        bus3.W       = 24'hC2B1A0;
        bus3.W_valid = 3'b000;
        bus3.y_ready = 1'b0;

        // Reset held with every channel valid.
        repeat (3) tick();
        check("reset y", {24'd0, bus4.y}, 32'h0);
        check("reset y_valid", {31'd0, bus4.y_valid}, 32'h0);
        check("reset y_sel", {30'd0, bus4.y_sel}, 32'h0);
        check("reset W_ready", {28'd0, bus4.W_ready}, 32'h0);

        // Release; round-robin with all valid cycles 0,1,2,3,0,1,2,3.
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp4_q.push_back({2'(k % 4), 8'(8'h11 * ((k % 4) + 1))});
        end
        for (int k = 0; k < 8; k++) begin
            check("rr all W_ready", {28'd0, bus4.W_ready}, 32'(4'b0001 << (k % 4)));
            tick();
        end

        // Valid pattern 1010 from ptr=0 grants 1,3,1.
        bus4.W_valid = 4'b1010;
        exp4_q.push_back({2'd1, 8'h22});
        exp4_q.push_back({2'd3, 8'h44});
        exp4_q.push_back({2'd1, 8'h22});
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rr 1010 W_ready", {28'd0, bus4.W_ready}, {28'd0, rr_ready[k]});
            tick();
        end
        bus4.W_valid = 4'b0000;
        tick();
        check("rr drained y_valid", {31'd0, bus4.y_valid}, 32'h0);

        // Manual select of channel 2 (ptr is 2 here and must stay 2).
        mode4        = 1'b0;
        s4           = 2'd2;
        bus4.W_valid = 4'b0100;
        #1;
        check("manual W_ready", {28'd0, bus4.W_ready}, 32'h4);
        exp4_q.push_back({2'd2, 8'h33});
        tick();
        check("manual y", {24'd0, bus4.y}, 32'h33);
        check("manual y_sel", {30'd0, bus4.y_sel}, 32'h2);
        bus4.W_valid = 4'b0000;
        tick();
        check("manual drop y_valid", {31'd0, bus4.y_valid}, 32'h0);

        // Backpressure: load A5 on channel 0, then stall three cycles while inputs move.
        bus4.W       = 32'h443322A5;
        s4           = 2'd0;
        bus4.W_valid = 4'b0001;
        bus4.y_ready = 1'b0;
        exp4_q.push_back({2'd0, 8'hA5});
        tick();
        for (int k = 0; k < 3; k++) begin
            bus4.W       = 32'h5A5A5A5A ^ 32'(k);
            bus4.W_valid = 4'hF;
            s4           = 2'(k + 1);
            #1;
            check("stall W_ready", {28'd0, bus4.W_ready}, 32'h0);
            check("stall y", {24'd0, bus4.y}, 32'hA5);
            check("stall y_valid", {31'd0, bus4.y_valid}, 32'h1);
            tick();
        end
        bus4.W       = 32'h443322A5;
        s4           = 2'd1;
        bus4.y_ready = 1'b1;
        #1;
        check("unstall W_ready", {28'd0, bus4.W_ready}, 32'h2);
        exp4_q.push_back({2'd1, 8'h22});
        tick();
        check("unstall y", {24'd0, bus4.y}, 32'h22);
        bus4.W_valid = 4'b0000;
        tick();

        // Three channels: move ptr to 2 with a round-robin grant of channel 1.
        mode3        = 1'b1;
        bus3.W_valid = 3'b010;
        bus3.y_ready = 1'b1;
        exp3_q.push_back({2'd1, 8'hB1});
        tick();
        // Out-of-range manual select grants nothing.
        mode3        = 1'b0;
        s3           = 2'd3;
        bus3.W_valid = 3'b111;
        #1;
        check("S=3 W_ready", {29'd0, bus3.W_ready}, 32'h0);
        tick();
        check("S=3 y_valid", {31'd0, bus3.y_valid}, 32'h0);
        // Back to round-robin: ptr retained at 2, so grants 2 then 0.
        mode3 = 1'b1;
        #1;
        check("rr3 first W_ready", {29'd0, bus3.W_ready}, 32'h4);
        exp3_q.push_back({2'd2, 8'hC2});
        exp3_q.push_back({2'd0, 8'hA0});
        tick();
        check("rr3 first y_sel", {30'd0, bus3.y_sel}, 32'h2);
        tick();
        check("rr3 second y_sel", {30'd0, bus3.y_sel}, 32'h0);
        bus3.W_valid = 3'b000;
        tick();
        check("rr3 drained y_valid", {31'd0, bus3.y_valid}, 32'h0);

        // Mid-stream reset: hold a word under backpressure, then reset between edges.
        mode4        = 1'b1;
        bus4.W_valid = 4'hF;
        bus4.y_ready = 1'b0;
        tick();
        check("held y_sel from ptr", {30'd0, bus4.y_sel}, 32'h2);
        check("held y_valid", {31'd0, bus4.y_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst y_valid", {31'd0, bus4.y_valid}, 32'h0);
        check("async rst y", {24'd0, bus4.y}, 32'h0);
        check("async rst y_sel", {30'd0, bus4.y_sel}, 32'h0);
        check("async rst W_ready", {28'd0, bus4.W_ready}, 32'h0);
        repeat (2) tick();
        rst_n        = 1'b1;
        bus4.y_ready = 1'b1;
        #1;
        check("post rst W_ready", {28'd0, bus4.W_ready}, 32'h1);
        exp4_q.push_back({2'd0, 8'hA5});
        exp4_q.push_back({2'd1, 8'h22});
        repeat (2) tick();
        bus4.W_valid = 4'b0000;
        repeat (2) tick();

        check("dut4 queue empty", 32'(exp4_q.size()), 32'h0);
        check("dut3 queue empty", 32'(exp3_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
